// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 constants, state codes and echo-width helper.
// HCSR04_EMU_TIMEOUT_EN selects the 38 ms no-object echo instead of clamping.
package hcsr04_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_TRIG  = 3'd1;
   localparam logic [2:0] ST_DELAY = 3'd2;
   localparam logic [2:0] ST_ECHO  = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   localparam int US_PER_CM  = 58;
   localparam int TIMEOUT_US = 38_000;
   localparam int MIN_CM     = 2;

   // Echo width in microseconds for a latched distance.
   function automatic logic [21:0] echo_width_us(
      input logic [15:0] d,
      input logic [15:0] max_cm
   );
      logic [15:0] eff;
`ifdef HCSR04_EMU_TIMEOUT_EN
      eff = d;
      if (d == 16'd0 || d > max_cm) return 22'(TIMEOUT_US);
`else
      if (d < 16'(MIN_CM))  eff = 16'(MIN_CM);
      else if (d > max_cm)  eff = max_cm;
      else                  eff = d;
`endif
      return 22'(eff) * 22'(US_PER_CM);
   endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_tick.sv
// Microsecond prescaler: one-cycle tick every US_TICKS clocks.
// A synchronous restart realigns the tick phase to a state entry.
module tick_gen_us #(
   parameter int US_TICKS = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic i_restart,
   output logic o_tick
);
   localparam int CW = $clog2(US_TICKS + 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == CW'(US_TICKS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_cnt <= '0;
      else if (i_restart) r_cnt <= '0;
      else if (o_tick)    r_cnt <= '0;
      else                r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 sensor stand-in: validates trigger, delays, emits distance echo.
// Optional HCSR04_EMU_TIMEOUT_EN (see hcsr04_pkg) gives the no-object echo.
module hcsr04_echo_emulator
   import hcsr04_pkg::*;
#(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int TRIG_MIN_US   = 10,
   parameter int ECHO_DELAY_US = 250,
   parameter int HOLDOFF_US    = 60_000,
   parameter int MAX_CM        = 400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trigger,
   input  logic [15:0] distance_cm,
   output logic        echo,
   output logic        busy,
   output logic        trig_err
);
   localparam int          US_TICKS = CLK_FREQ / 1_000_000;
   localparam logic [21:0] TRIG_CYC = 22'(TRIG_MIN_US * US_TICKS);
   localparam logic [21:0] DLY_LAST = 22'(ECHO_DELAY_US - 1);
   localparam logic [21:0] HLD_LAST = 22'(HOLDOFF_US - 1);

   logic        r_sync1, r_sync2, r_trig_d;
   logic [2:0]  r_state, w_next;
   logic [21:0] r_cnt;
   logic [15:0] r_dist;
   logic        r_echo, r_busy, r_err;
   logic        w_rise, w_fall, w_long, w_tick, w_restart;
   logic        w_echo_n, w_busy_n, w_err_n;
   logic [21:0] w_wid_last;

   assign w_rise     = r_sync2 & ~r_trig_d;
   assign w_fall     = ~r_sync2 & r_trig_d;
   assign w_long     = (r_cnt >= TRIG_CYC);
   assign w_wid_last = echo_width_us(r_dist, 16'(MAX_CM)) - 22'd1;
   assign w_restart  = (w_next != r_state) &&
                       (w_next == ST_DELAY || w_next == ST_ECHO ||
                        w_next == ST_HOLD);

   tick_gen_us #(.US_TICKS(US_TICKS)) u_tick (
      .clk       (clk),
      .reset     (reset),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_trig_d <= 1'b0;
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dist   <= '0;
         r_echo   <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_sync1  <= trigger;
         r_sync2  <= r_sync1;
         r_trig_d <= r_sync2;
         r_state  <= w_next;
         r_echo   <= w_echo_n;
         r_busy   <= w_busy_n;
         r_err    <= w_err_n;
         if (r_state == ST_TRIG && w_fall && w_long)
            r_dist <= distance_cm;
         // The rising-edge cycle is itself a high cycle, so it counts as 1.
         if (w_restart)
            r_cnt <= '0;
         else if (r_state == ST_IDLE)
            r_cnt <= {21'd0, w_rise};
         else if (r_state == ST_TRIG) begin
            if (r_sync2 && !w_long) r_cnt <= r_cnt + 22'd1;
         end else if (w_tick)
            r_cnt <= r_cnt + 22'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_rise) w_next = ST_TRIG;
         ST_TRIG:  if (w_fall) w_next = w_long ? ST_DELAY : ST_IDLE;
         ST_DELAY: if (w_tick && r_cnt == DLY_LAST)   w_next = ST_ECHO;
         ST_ECHO:  if (w_tick && r_cnt == w_wid_last) w_next = ST_HOLD;
         ST_HOLD:  if (w_tick && r_cnt == HLD_LAST)   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_echo_n = (w_next == ST_ECHO);
      w_busy_n = (w_next == ST_DELAY) || (w_next == ST_ECHO) ||
                 (w_next == ST_HOLD);
      w_err_n  = (r_state == ST_TRIG) && w_fall && !w_long;
   end

   assign echo     = r_echo;
   assign busy     = r_busy;
   assign trig_err = r_err;

endmodule
